// File: rtl/shifter_pkg.sv
// Shared opcodes and FSM state encoding for the iterative shifter.
// Rotate opcodes are only decoded when SHIFTER_ROTATE_EN is defined.
package shifter_pkg;
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/shifter_seq_n_shift_step.sv
// Single shift/rotate step of 0..MAX_STEP bits; non-shift opcodes pass data.
// Rotate paths exist only when SHIFTER_ROTATE_EN is defined.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_STEP = 2
) (
  input  logic [2:0]                     op,
  input  logic [$clog2(MAX_STEP+1)-1:0]  step,
  input  logic [WIDTH-1:0]               data,
  output logic [WIDTH-1:0]               result
);
`ifdef SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] dd;
`endif

  always_comb begin
    result = data;
`ifdef SHIFTER_ROTATE_EN
    dd = '0;
`endif
    case (op)
      OP_LSL: result = data << step;
      OP_LSR: result = data >> step;
      OP_ASR: result = $unsigned($signed(data) >>> step);
`ifdef SHIFTER_ROTATE_EN
      // Doubled word turns the rotate into a plain shift plus a window select.
      OP_ROL: begin
        dd     = {data, data} << step;
        result = dd[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dd     = {data, data} >> step;
        result = dd[WIDTH-1:0];
      end
`endif
      default: result = data;
    endcase
  end
endmodule

// File: rtl/shifter_seq_n.sv
// Registered WIDTH-bit shifter executing shifts MAX_STEP bits per clock
// with a ready/done handshake. Optional rotates: SHIFTER_ROTATE_EN.
module shifter_seq_n
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_STEP = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      op_valid,
  input  logic [2:0]                op,
  input  logic [$clog2(WIDTH)-1:0]  shamt,
  input  logic [WIDTH-1:0]          d_in,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          d_out
);
  localparam int SHW = $clog2(WIDTH);
  localparam int STW = $clog2(MAX_STEP + 1);
  localparam logic [SHW-1:0] MAX_S = SHW'(MAX_STEP);

  function automatic logic is_shift(input logic [2:0] o);
`ifdef SHIFTER_ROTATE_EN
    return o inside {OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR};
`else
    return o inside {OP_LSL, OP_LSR, OP_ASR};
`endif
  endfunction

  state_t           state, state_nxt;
  logic [2:0]       op_q, cur_op;
  logic [SHW-1:0]   rem, amt, step_w, rem_nxt;
  logic [STW-1:0]   step;
  logic [WIDTH-1:0] step_out, d_nxt;
  logic             accept, last, done_nxt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Step sizing: non-shift ops see amt = 0, so they complete in one edge.
  always_comb begin
    accept  = (state == ST_IDLE) && op_valid;
    cur_op  = (state == ST_IDLE) ? op : op_q;
    amt     = (state == ST_IDLE) ? (is_shift(op) ? shamt : '0) : rem;
    step_w  = (amt > MAX_S) ? MAX_S : amt;
    step    = step_w[STW-1:0];
    rem_nxt = amt - step_w;
    last    = (rem_nxt == '0);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && !last) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last)            state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state == ST_IDLE);
    busy  = ~ready;
  end

  shift_step #(.WIDTH(WIDTH), .MAX_STEP(MAX_STEP)) u_step (
    .op     (cur_op),
    .step   (step),
    .data   (d_out),
    .result (step_out)
  );

  always_comb begin
    d_nxt = d_out;
    if (state == ST_SHIFT)  d_nxt = step_out;
    else if (accept)        d_nxt = (op == OP_LOAD) ? d_in : step_out;
    done_nxt = (accept || state == ST_SHIFT) && last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_out <= '0;
      done  <= 1'b0;
      rem   <= '0;
      op_q  <= OP_NOP;
    end else begin
      d_out <= d_nxt;
      done  <= done_nxt;
      if (accept || state == ST_SHIFT) rem <= rem_nxt;
      if (accept) op_q <= op;
    end
  end
endmodule
